// File: rtl/dm_block_memory.sv
// Block-granular 256 x 32-bit main memory behind a req/ready handshake with a
// fixed, parameterised access latency and a combinational debug word port.
module dm_block_memory #(
   parameter int unsigned LATENCY = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req,
   input  logic         we,
   input  logic [9:0]   addr,
   input  logic [127:0] wdata,
   output logic [127:0] rdata,
   output logic         ready,
   output logic         busy,
   input  logic [7:0]   dbg_addr,
   output logic [31:0]  dbg_data
);

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned WORDS   = 256;
   localparam int unsigned WPB     = 4;
   localparam int unsigned BLK_W   = 6;
   localparam int unsigned BLOCK_W = WORD_W * WPB;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 we_q, we_d;
   logic [BLK_W-1:0]     blk_q, blk_d;
   logic [BLOCK_W-1:0]   wdata_q, wdata_d;
   logic [BLOCK_W-1:0]   rdata_q, rdata_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 mem_wr_c;
   logic [BLOCK_W-1:0]   rd_blk_c;
   logic [WORD_W-1:0]    mem_q [WORDS];

   // Byte offset within a block carries no information at block granularity.
   logic                 unused_addr_c;
   assign unused_addr_c = ^addr[3:0];

   // Gather the latched block's four words, word k in bits [32k+31:32k].
   always_comb begin
      rd_blk_c = '0;
      for (int k = 0; k < int'(WPB); k++) begin
         rd_blk_c[k*WORD_W +: WORD_W] = mem_q[{blk_q, 2'(k)}];
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      blk_d    = blk_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      mem_wr_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               we_d    = we;
               blk_d   = addr[9:4];
               wdata_d = wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (we_q) begin
                  mem_wr_c = 1'b1;
               end else begin
                  rdata_d = rd_blk_c;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
   end

   // State, datapath and storage registers; reset reinitialises word w to w.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         blk_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         for (int w = 0; w < int'(WORDS); w++) begin
            mem_q[8'(w)] <= WORD_W'(w);
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         blk_q   <= blk_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         if (mem_wr_c) begin
            for (int k = 0; k < int'(WPB); k++) begin
               mem_q[{blk_q, 2'(k)}] <= wdata_q[k*WORD_W +: WORD_W];
            end
         end
      end
   end

   assign rdata    = rdata_q;
   assign ready    = ready_q;
   assign busy     = busy_q;
   assign dbg_data = mem_q[dbg_addr];

endmodule

// File: doc/dm_block_memory.md
# dm_block_memory

Block-granular main data memory serving the write-back direct-mapped cache's miss path. It accepts one 128-bit block read or write per request over a request/ready handshake, with a fixed, parameterised access latency, so the cache controller sees realistic multi-cycle refills and write-backs. A combinational debug port exposes any 32-bit word for on-board display of memory contents.

## Interface
- `LATENCY`, default 4: number of BUSY cycles per access; legal range 1..15.
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `rst_n` input, 1: synchronous, active-low reset.
- `req` input, 1: access request; sampled only in IDLE.
- `we` input, 1: 1 = block write, 0 = block read; sampled with `req`.
- `addr` input, 10: byte address. Block index = `addr[9:4]` (64 blocks); `addr[3:0]` is ignored.
- `wdata` input, 128: write block. Word k occupies bits [32k+31:32k].
- `rdata` output, 128: read block, same word packing as `wdata`.
- `ready` output, 1: one-cycle completion pulse.
- `busy` output, 1: high whenever the state is not IDLE.
- `dbg_addr` input, 8: word index, 0..255.
- `dbg_data` output, 32: current contents of word `dbg_addr`, combinational.

## Operation
- Storage is 256 x 32-bit words. Block b holds words 4b..4b+3, with word 4b+k at block bits [32k+31:32k].
- Reset (`rst_n`=0 at an edge):
  - state <= IDLE; `ready`, `busy` = 0; `rdata` <= 0; counter <= 0.
  - Every word w <= w, zero-extended to 32 bits.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, `req`=1: latch `we`, `addr[9:4]` and `wdata` into internal registers; counter <= LATENCY-1; go to BUSY.
  - IDLE, `req`=0: stay in IDLE.
  - BUSY, counter != 0: decrement the counter.
  - BUSY, counter == 0, latched write: store the latched block into memory. Go to DONE.
  - BUSY, counter == 0, latched read: `rdata` <= stored block. Go to DONE.
  - DONE: `ready`=1 for this cycle only; go to IDLE unconditionally.
- `req`, `we`, `addr` and `wdata` are ignored in BUSY and DONE. A request held high through completion is accepted again in the next IDLE cycle, which is a new access.
- `rdata` holds its value until the next read completes. Write completions and reset-free idle periods leave it unchanged.
- Inputs are latched, so the requester may change them after the accept edge without affecting the access in flight.
- Reset mid-access aborts it:
  - no partial or deferred write takes place;
  - memory is reinitialised;
  - no `ready` pulse is issued.
- `dbg_data` reflects the array directly. A completed write is visible on it from the DONE cycle onward.

## Timing
- Let `req`=1 be sampled in IDLE at the edge ending cycle t.
  - BUSY occupies cycles t+1 .. t+LATENCY.
  - DONE (`ready`=1) is cycle t+LATENCY+1.
  - The earliest next accept is at the end of cycle t+LATENCY+2.
- `busy`=1 for cycles t+1 .. t+LATENCY+1 inclusive.
- Throughput is one access per LATENCY+2 cycles.
- `ready` is registered, never combinational from `req`.
- `rdata` is valid in the same cycle `ready` is high, and remains stable afterwards.

## Test plan
- **Reset contents.** Assert `rst_n`=0 for 1 cycle, then sweep `dbg_addr` over 0..255 -> `dbg_data` == `dbg_addr`. `ready`=0, `busy`=0, `rdata`=0.
- **Read latency.** LATENCY=4. Read `addr`=10'h014 -> `busy` high 5 cycles, `ready` pulses in the 5th cycle after accept, `rdata`={32'd7,32'd6,32'd5,32'd4}.
- **Write then read, same block.** Write `addr`=10'h3F8 with `wdata`={32'hD,32'hC,32'hB,32'hA}.
  - `dbg_addr`=252 reads 32'hA from the DONE cycle; `rdata` is unchanged by the write.
  - A following read of 10'h3F0 returns the same block.
- **Held request / ignored inputs.** Hold `req`=1 continuously and change `addr`/`wdata` while BUSY -> the first access uses the latched values. A second access starts exactly one cycle after the `ready` pulse.
- **Reset mid-write.** Issue a write to block 2, then drop `rst_n` in the 2nd BUSY cycle.
  - Next cycle: IDLE, `busy`=0, no `ready` pulse.
  - Words 8..11 read 8..11 on `dbg_data`.
- **LATENCY=1 build.** Read block 63 -> `ready` in the 2nd cycle after accept, `rdata`={32'd255,32'd254,32'd253,32'd252}.
